sha1_stream_padder: RTL and testbench

//  Front end for sha1_exec. Accepts an arbitrary-length byte message as a beat stream and packs it
//  big-endian into 32-bit words. Applies FIPS 180 padding (0x80, zero fill, 64-bit bit-length) and

---
 rtl/sha1_stream_padder.sv | 198 +++++++++++++++++++
 tb/tb_sha1_stream_padder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_stream_padder.sv
// Packs a byte beat stream big-endian into 32-bit words, adds SHA-1 padding and sequences sha1_exec blocks.
// Latency: accepted beat -> load_in 1 cycle, last load_in -> start 1 cycle; in_ready drops outside FILL.
module sha1_stream_padder #(
    parameter int  IN_BYTES = 4,
    parameter int  LEN_W    = 32,
    localparam int NB_W     = $clog2(IN_BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [8*IN_BYTES-1:0]   in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic [NB_W-1:0]         in_nbytes,
    output logic                    in_ready,
    output logic [31:0]             data_in,
    output logic                    load_in,
    output logic                    start,
    output logic                    use_prev_cv,
    output logic [159:0]            cv,
    input  logic                    core_busy,
    output logic                    msg_busy,
    output logic                    digest_valid
);
    typedef enum logic [1:0] {S_FILL, S_PAD, S_START, S_WAIT} state_t;

    state_t             state_q, state_d;
    logic [4:0]         word_cnt_q, word_cnt_d;
    logic [LEN_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [31:0]        asm_q, asm_d;
    logic [2:0]         asm_cnt_q, asm_cnt_d;
    logic               first_q, first_d;
    logic               pad_pend_q, pad_pend_d;
    logic               spill_q, spill_d;
    logic               done_q, done_d;
    logic               wait1_q, wait1_d;
    logic               busy_q, busy_d;
    logic               load_q, load_d;
    logic [31:0]        data_q, data_d;
    logic               start_q, start_d;
    logic               prev_q, prev_d;
    logic               dig_q, dig_d;

    logic [31:0]        merged, padded;
    logic [63:0]        len64;
    int                 mcnt;

    assign in_ready     = (state_q == S_FILL);
    assign load_in      = load_q;
    assign data_in      = data_q;
    assign start        = start_q;
    assign use_prev_cv  = prev_q;
    assign msg_busy     = busy_q;
    assign digest_valid = dig_q;
    assign cv           = 160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0;
    assign len64        = 64'(byte_cnt_q) << 3;

    // Beat bytes land left-aligned after the bytes already held; padded adds the 0x80 marker after them.
    always_comb begin
        merged = asm_q;
        mcnt   = int'(asm_cnt_q);
        for (int i = 0; i < IN_BYTES; i++) begin
            if (i < int'(in_nbytes) && mcnt < 4) begin
                merged[8*(3-mcnt) +: 8] = in_data[8*(IN_BYTES-1-i) +: 8];
                mcnt = mcnt + 1;
            end
        end
        padded = merged;
        if (mcnt < 4) padded[8*(3-mcnt) +: 8] = 8'h80;
    end

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        asm_cnt_d  = asm_cnt_q;
        first_d    = first_q;
        pad_pend_d = pad_pend_q;
        spill_d    = spill_q;
        done_d     = done_q;
        wait1_d    = 1'b0;
        busy_d     = busy_q;
        load_d     = 1'b0;
        data_d     = 32'h0;
        start_d    = 1'b0;
        prev_d     = 1'b0;
        dig_d      = 1'b0;
        case (state_q)
            S_FILL: begin
                if (in_valid) begin
                    busy_d     = 1'b1;
                    byte_cnt_d = byte_cnt_q + LEN_W'(in_nbytes);
                    if (in_last || mcnt == 4) begin
                        load_d     = 1'b1;
                        asm_d      = 32'h0;
                        asm_cnt_d  = 3'd0;
                        word_cnt_d = word_cnt_q + 5'd1;
                        data_d     = merged;
                        if (word_cnt_q == 5'd15) state_d = S_START;
                        else if (in_last)        state_d = S_PAD;
                    end else begin
                        asm_d     = merged;
                        asm_cnt_d = 3'(mcnt);
                    end
                    if (in_last) begin
                        done_d = 1'b1;
                        // A full final word still owes the 0x80 marker in a word of its own.
                        if (mcnt == 4) pad_pend_d = 1'b1;
                        else begin
                            data_d = padded;
                            if (word_cnt_q >= 5'd14) spill_d = 1'b1;
                        end
                    end
                end
            end
            S_PAD: begin
                load_d     = 1'b1;
                word_cnt_d = word_cnt_q + 5'd1;
                if (pad_pend_q) begin
                    data_d     = 32'h8000_0000;
                    pad_pend_d = 1'b0;
                    if (word_cnt_q >= 5'd14) spill_d = 1'b1;
                end else if (word_cnt_q == 5'd14 && !spill_q) begin
                    data_d = len64[63:32];
                end else if (word_cnt_q == 5'd15 && !spill_q) begin
                    data_d = len64[31:0];
                end
                if (word_cnt_q == 5'd15) state_d = S_START;
            end
            S_START: begin
                start_d    = 1'b1;
                prev_d     = ~first_q;
                first_d    = 1'b0;
                word_cnt_d = 5'd0;
                wait1_d    = 1'b1;
                state_d    = S_WAIT;
            end
            default: begin
                // The start cycle itself is ignored: the core has not yet raised busy.
                if (!wait1_q && !core_busy) begin
                    if (pad_pend_q) begin
                        state_d = S_PAD;
                    end else if (spill_q) begin
                        spill_d = 1'b0;
                        state_d = S_PAD;
                    end else if (!done_q) begin
                        state_d = S_FILL;
                    end else begin
                        dig_d      = 1'b1;
                        byte_cnt_d = '0;
                        first_d    = 1'b1;
                        done_d     = 1'b0;
                        busy_d     = 1'b0;
                        state_d    = S_FILL;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_FILL;
            word_cnt_q <= 5'd0;
            byte_cnt_q <= '0;
            asm_q      <= 32'h0;
            asm_cnt_q  <= 3'd0;
            first_q    <= 1'b1;
            pad_pend_q <= 1'b0;
            spill_q    <= 1'b0;
            done_q     <= 1'b0;
            wait1_q    <= 1'b0;
            busy_q     <= 1'b0;
            load_q     <= 1'b0;
            data_q     <= 32'h0;
            start_q    <= 1'b0;
            prev_q     <= 1'b0;
            dig_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            asm_cnt_q  <= asm_cnt_d;
            first_q    <= first_d;
            pad_pend_q <= pad_pend_d;
            spill_q    <= spill_d;
            done_q     <= done_d;
            wait1_q    <= wait1_d;
            busy_q     <= busy_d;
            load_q     <= load_d;
            data_q     <= data_d;
            start_q    <= start_d;
            prev_q     <= prev_d;
            dig_q      <= dig_d;
        end
    end
endmodule

// File: tb/tb_sha1_stream_padder.sv
// Scoreboard bench: two padder instances (4-byte and 1-byte beats) against a byte-level padding model.
module tb_sha1_stream_padder;
    typedef struct packed { logic [1:0] kind; logic [31:0] dat; } exp_t;
    localparam logic [1:0] K_LOAD = 2'd0, K_START = 2'd1, K_DIG = 2'd2;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic [31:0]  in_data4;  logic in_valid4, in_last4; logic [2:0] in_nbytes4; logic in_ready4;
    logic [31:0]  data_in4;  logic load_in4, start4, use_prev_cv4, core_busy4, msg_busy4, digest_valid4;
    logic [159:0] cv4;
    logic [7:0]   in_data1;  logic in_valid1, in_last1; logic [0:0] in_nbytes1; logic in_ready1;
    logic [31:0]  data_in1;  logic load_in1, start1, use_prev_cv1, core_busy1, msg_busy1, digest_valid1;
    logic [159:0] cv1;

    sha1_stream_padder #(.IN_BYTES(4), .LEN_W(32)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data4), .in_valid(in_valid4), .in_last(in_last4),
        .in_nbytes(in_nbytes4), .in_ready(in_ready4), .data_in(data_in4), .load_in(load_in4),
        .start(start4), .use_prev_cv(use_prev_cv4), .cv(cv4), .core_busy(core_busy4),
        .msg_busy(msg_busy4), .digest_valid(digest_valid4));

    sha1_stream_padder #(.IN_BYTES(1), .LEN_W(16)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data1), .in_valid(in_valid1), .in_last(in_last1),
        .in_nbytes(in_nbytes1), .in_ready(in_ready1), .data_in(data_in1), .load_in(load_in1),
        .start(start1), .use_prev_cv(use_prev_cv1), .cv(cv1), .core_busy(core_busy1),
        .msg_busy(msg_busy1), .digest_valid(digest_valid1));

    int vectors = 0;
    int miscompares = 0;
    exp_t exp4_q[$];
    exp_t exp1_q[$];
    exp_t model_q[$];
    byte unsigned msg[$];
    int busy_cnt4 = 0;
    int busy_cnt1 = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %08h, expected %08h", nm, act, req);
        end
    endtask

    // Reference: FIPS 180 padding on the byte array, then 16 words per 64-byte block.
    function automatic void build_model();
        byte unsigned p[$];
        longint unsigned bits;
        model_q.delete();
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bits = 64'(msg.size()) * 8;
        for (int k = 7; k >= 0; k--) p.push_back(8'(bits >> (8 * k)));
        for (int b = 0; b < p.size() / 64; b++) begin
            for (int w = 0; w < 16; w++) begin
                int o = b * 64 + w * 4;
                model_q.push_back('{kind: K_LOAD, dat: {p[o], p[o+1], p[o+2], p[o+3]}});
            end
            model_q.push_back('{kind: K_START, dat: 32'(b != 0)});
        end
        model_q.push_back('{kind: K_DIG, dat: 32'h0});
    endfunction

    task automatic expect_msg(input bit four);
        build_model();
        foreach (model_q[k]) begin
            if (four) exp4_q.push_back(model_q[k]);
            else      exp1_q.push_back(model_q[k]);
        end
    endtask

    task automatic pop_cmp(input bit four, input logic [1:0] kind, input logic [31:0] dat, input string nm);
        exp_t e;
        if ((four && exp4_q.size() == 0) || (!four && exp1_q.size() == 0)) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: unexpected output %08h, expected nothing", nm, dat);
            return;
        end
        if (four) e = exp4_q.pop_front();
        else      e = exp1_q.pop_front();
        check({nm, "_kind"}, 32'(kind), 32'(e.kind));
        check(nm, dat, e.dat);
    endtask

    // Monitors plus a sha1_exec stand-in that holds core_busy for a random time after each start.
    always @(negedge clk) begin
        if (!reset_n) begin
            busy_cnt4 = 0;
            busy_cnt1 = 0;
        end else begin
            if (load_in4) begin
                check("load_while_busy4", 32'(core_busy4), 32'd0);
                pop_cmp(1'b1, K_LOAD, data_in4, "load4");
            end
            if (start4) begin
                pop_cmp(1'b1, K_START, 32'(use_prev_cv4), "start4");
                check("msg_busy4_at_start", 32'(msg_busy4), 32'd1);
            end
            if (digest_valid4) pop_cmp(1'b1, K_DIG, 32'h0, "digest4");
            if (load_in1) begin
                check("load_while_busy1", 32'(core_busy1), 32'd0);
                pop_cmp(1'b0, K_LOAD, data_in1, "load1");
            end
            if (start1) begin
                pop_cmp(1'b0, K_START, 32'(use_prev_cv1), "start1");
                check("msg_busy1_at_start", 32'(msg_busy1), 32'd1);
            end
            if (digest_valid1) pop_cmp(1'b0, K_DIG, 32'h0, "digest1");
            if (start4) busy_cnt4 = int'($urandom_range(20, 1));
            else if (busy_cnt4 > 0) busy_cnt4--;
            if (start1) busy_cnt1 = int'($urandom_range(20, 1));
            else if (busy_cnt1 > 0) busy_cnt1--;
        end
        core_busy4 = (busy_cnt4 > 0);
        core_busy1 = (busy_cnt1 > 0);
    end

    task automatic beat4(input logic [31:0] d, input logic [2:0] nb, input logic last);
        int t = 0;
        in_data4 = d; in_nbytes4 = nb; in_last4 = last; in_valid4 = 1'b1;
        while (!in_ready4 && t < 1000) begin @(negedge clk); t++; end
        if (!in_ready4) check("in_ready4_timeout", 32'(in_ready4), 32'd1);
        @(negedge clk);
        in_valid4 = 1'b0; in_last4 = 1'b0;
        if (!last) repeat ($urandom_range(2, 0)) @(negedge clk);
    endtask

    task automatic beat1(input logic [7:0] d, input logic [0:0] nb, input logic last);
        int t = 0;
        in_data1 = d; in_nbytes1 = nb; in_last1 = last; in_valid1 = 1'b1;
        while (!in_ready1 && t < 1000) begin @(negedge clk); t++; end
        if (!in_ready1) check("in_ready1_timeout", 32'(in_ready1), 32'd1);
        @(negedge clk);
        in_valid1 = 1'b0; in_last1 = 1'b0;
        if (!last) repeat ($urandom_range(3, 0)) @(negedge clk);
    endtask

    task automatic send4();
        int n = msg.size();
        int i = 0;
        int nb;
        bit extra;
        logic [31:0] d;
        extra = (n == 0) || ((n % 4 == 0) && ($urandom_range(1, 0) == 1));
        expect_msg(1'b1);
        while (i < n) begin
            nb = (n - i > 4) ? 4 : n - i;
            d = $urandom;
            for (int j = 0; j < nb; j++) d[31-8*j -: 8] = msg[i+j];
            beat4(d, 3'(nb), !extra && (i + nb == n));
            i += nb;
        end
        if (extra) beat4($urandom, 3'd0, 1'b1);
    endtask

    task automatic send1();
        int n = msg.size();
        int t = 0;
        int bad = 0;
        bit extra;
        extra = (n == 0) || ($urandom_range(3, 0) == 0);
        expect_msg(1'b0);
        for (int i = 0; i < n; i++) beat1(msg[i], 1'b1, !extra && (i == n - 1));
        if (extra) beat1(8'($urandom), 1'b0, 1'b1);
        while (!digest_valid1 && t < 20000) begin
            if (in_ready1) bad++;
            @(negedge clk);
            t++;
        end
        check("in_ready1_low_until_digest", 32'(bad), 32'd0);
        check("digest1_reached", 32'(digest_valid1), 32'd1);
    endtask

    task automatic drain(input bit four, input string nm);
        int t = 0;
        while (((four && exp4_q.size() != 0) || (!four && exp1_q.size() != 0)) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check({nm, "_outstanding"}, four ? 32'(exp4_q.size()) : 32'(exp1_q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset();
        check("rst_ctl4", 32'({in_ready4, load_in4, start4, use_prev_cv4, msg_busy4, digest_valid4}), 32'h20);
        check("rst_data4", data_in4, 32'h0);
        check("rst_ctl1", 32'({in_ready1, load_in1, start1, use_prev_cv1, msg_busy1, digest_valid1}), 32'h20);
        check("rst_data1", data_in1, 32'h0);
    endtask

    task automatic set_str(input string s);
        msg.delete();
        for (int k = 0; k < s.len(); k++) msg.push_back(s[k]);
    endtask

    task automatic set_rand(input int n);
        msg.delete();
        repeat (n) msg.push_back(8'($urandom));
    endtask

    initial begin
        reset_n = 1'b0;
        in_data4 = '0; in_valid4 = 1'b0; in_last4 = 1'b0; in_nbytes4 = '0;
        in_data1 = '0; in_valid1 = 1'b0; in_last1 = 1'b0; in_nbytes1 = '0;
        core_busy4 = 1'b0; core_busy1 = 1'b0;
        repeat (3) @(negedge clk);
        check_reset();
        reset_n = 1'b1;
        @(negedge clk);
        check("cv4_hi", cv4[159:128], 32'h67452301);
        check("cv1_lo", cv1[31:0], 32'hC3D2E1F0);

        set_str("abc"); send4(); drain(1'b1, "abc4");
        set_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"); send4(); drain(1'b1, "len56");
        msg.delete(); send4(); drain(1'b1, "empty4");
        set_rand(64); send4(); drain(1'b1, "len64");
        set_rand(55); send4(); drain(1'b1, "len55");
        set_rand(63); send4(); drain(1'b1, "len63");
        set_rand(57); send4(); drain(1'b1, "len57");
        for (int r = 0; r < 8; r++) begin
            set_rand(int'($urandom_range(200, 0))); send4(); drain(1'b1, "rand4");
        end

        set_str("abc"); send1(); drain(1'b0, "abc1");
        msg.delete(); send1(); drain(1'b0, "empty1");
        for (int r = 0; r < 4; r++) begin
            set_rand(int'($urandom_range(130, 0))); send1(); drain(1'b0, "rand1");
        end

        // Reset while the first block of the 56-byte message is still padding.
        set_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
        send4();
        #3 reset_n = 1'b0;
        #1 check_reset();
        exp4_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_after_reset_in_ready4", 32'(in_ready4), 32'd1);
        set_str("abc"); send4(); drain(1'b1, "abc_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
